// File: rtl/pipe_pkg.sv
// Shared types and constants for the 16-bit pipeline: writeback select,
// writeback FSM states and the MEM/WB register layout.
package pipe_pkg;

   localparam int ARQ           = 16;
   localparam int REG_ADDR_SIZE = 4;

   typedef enum logic {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_sel_t;

   typedef enum logic {
      RUN,
      HALTED
   } wb_state_t;

   typedef struct packed {
      wb_sel_t                  sel;
      logic                     we;
      logic                     valid;
      logic                     halt;
      logic [REG_ADDR_SIZE-1:0] rd;
      logic [ARQ-1:0]           alu;
      logic [ARQ-1:0]           mem;
   } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: reset and flush load a bubble, stall holds,
// otherwise the MEM-stage bundle is captured every cycle.
module mem_wb_reg
   import pipe_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  logic    stall,
   input  logic    flush,
   input  mem_wb_t d_i,
   output mem_wb_t q_o
);

   mem_wb_t reg_q;
   mem_wb_t reg_d;

   // Flush outranks stall so a squashed instruction never lingers in WB.
   always_comb begin
      reg_d = reg_q;
      if (flush) begin
         reg_d = '0;
      end else if (!stall) begin
         reg_d = d_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_q <= '0;
      end else begin
         reg_q <= reg_d;
      end
   end

   assign q_o = reg_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: MEM/WB register, writeback mux, register-file write port,
// forwarding tap to EX, retire counter and a sticky halt FSM.
module wb_stage #(
   parameter int ARQ           = 16,
   parameter int REG_ADDR_SIZE = 4,
   parameter int CNT_W         = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     wb_mux_contrl,
   input  logic                     wb_enable_wb_in,
   input  logic                     pc_en_wb_in,
   input  logic                     halt_wb_in,
   input  logic [REG_ADDR_SIZE-1:0] rd_wb_in,
   input  logic [ARQ-1:0]           alu_result_wb_in,
   input  logic [ARQ-1:0]           mem_result_wb_in,
   output logic [ARQ-1:0]           wb_result_out,
   output logic                     wr_reg_en,
   output logic [REG_ADDR_SIZE-1:0] wr_reg_addr,
   output logic                     pc_en,
   output logic                     fwd_valid,
   output logic [REG_ADDR_SIZE-1:0] fwd_addr,
   output logic [ARQ-1:0]           fwd_data,
   output logic [CNT_W-1:0]         retired_count,
   output logic                     halted
);

   pipe_pkg::mem_wb_t   mem_in;
   pipe_pkg::mem_wb_t   mw;
   pipe_pkg::wb_state_t state_q;
   pipe_pkg::wb_state_t state_d;
   logic [CNT_W-1:0]    count_q;
   logic [CNT_W-1:0]    count_d;
   logic                retire;

   assign mem_in = '{
      sel:   pipe_pkg::wb_sel_t'(wb_mux_contrl),
      we:    wb_enable_wb_in,
      valid: pc_en_wb_in,
      halt:  halt_wb_in,
      rd:    rd_wb_in,
      alu:   alu_result_wb_in,
      mem:   mem_result_wb_in
   };

   mem_wb_reg u_mem_wb_reg (
      .clk   (clk),
      .rst   (rst),
      .stall (stall),
      .flush (flush),
      .d_i   (mem_in),
      .q_o   (mw)
   );

   // A held instruction must not retire while stalled, or it would retire twice.
   assign retire        = mw.valid && (state_q == pipe_pkg::RUN) && !stall;
   assign wb_result_out = (mw.sel == pipe_pkg::WB_MEM) ? mw.mem : mw.alu;
   assign wr_reg_en     = retire && mw.we && (mw.rd != '0);
   assign wr_reg_addr   = mw.rd;
   assign pc_en         = retire;

   assign fwd_valid     = wr_reg_en;
   assign fwd_addr      = wr_reg_addr;
   assign fwd_data      = wb_result_out;

   assign retired_count = count_q;
   assign halted        = (state_q == pipe_pkg::HALTED);

   // HALT retires in its own cycle; everything after it is architecturally dead.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      if (retire) begin
         count_d = count_q + CNT_W'(1);
         if (mw.halt) begin
            state_d = pipe_pkg::HALTED;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= pipe_pkg::RUN;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed vectors push the hand-computed outputs
// expected in each cycle; an independent monitor pops and compares mid-cycle.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        flush = 1'b0;
   logic        wb_mux_contrl = 1'b0;
   logic        wb_enable_wb_in = 1'b0;
   logic        pc_en_wb_in = 1'b0;
   logic        halt_wb_in = 1'b0;
   logic [3:0]  rd_wb_in = '0;
   logic [15:0] alu_result_wb_in = '0;
   logic [15:0] mem_result_wb_in = '0;
   logic [15:0] wb_result_out;
   logic        wr_reg_en;
   logic [3:0]  wr_reg_addr;
   logic        pc_en;
   logic        fwd_valid;
   logic [3:0]  fwd_addr;
   logic [15:0] fwd_data;
   logic [3:0]  retired_count;
   logic        halted;

   typedef struct {
      int          cyc;
      logic [15:0] res;
      logic        wen;
      logic [3:0]  addr;
      logic        pc;
      logic [3:0]  cnt;
      logic        hlt;
   } exp_t;

   exp_t expQ[$];
   int   compared = 0;
   int   mismatched = 0;
   int   cycle = 0;

   wb_stage #(.ARQ(16), .REG_ADDR_SIZE(4), .CNT_W(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .flush            (flush),
      .wb_mux_contrl    (wb_mux_contrl),
      .wb_enable_wb_in  (wb_enable_wb_in),
      .pc_en_wb_in      (pc_en_wb_in),
      .halt_wb_in       (halt_wb_in),
      .rd_wb_in         (rd_wb_in),
      .alu_result_wb_in (alu_result_wb_in),
      .mem_result_wb_in (mem_result_wb_in),
      .wb_result_out    (wb_result_out),
      .wr_reg_en        (wr_reg_en),
      .wr_reg_addr      (wr_reg_addr),
      .pc_en            (pc_en),
      .fwd_valid        (fwd_valid),
      .fwd_addr         (fwd_addr),
      .fwd_data         (fwd_data),
      .retired_count    (retired_count),
      .halted           (halted)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input int cyc, input logic [15:0] act, input logic [15:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, req);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      cmp("wb_result_out", e.cyc, wb_result_out, e.res);
      cmp("wr_reg_en", e.cyc, 16'(wr_reg_en), 16'(e.wen));
      cmp("wr_reg_addr", e.cyc, 16'(wr_reg_addr), 16'(e.addr));
      cmp("pc_en", e.cyc, 16'(pc_en), 16'(e.pc));
      cmp("retired_count", e.cyc, 16'(retired_count), 16'(e.cnt));
      cmp("halted", e.cyc, 16'(halted), 16'(e.hlt));
      cmp("fwd_data", e.cyc, fwd_data, e.res);
      cmp("fwd_valid", e.cyc, 16'(fwd_valid), 16'(e.wen));
      cmp("fwd_addr", e.cyc, 16'(fwd_addr), 16'(e.addr));
   endtask

   // Drives this cycle's inputs (captured at the next edge) and queues the outputs
   // expected during this cycle from what the previous edge loaded.
   task automatic applyStimulus(
      input logic r, input logic st, input logic fl, input logic sel,
      input logic we, input logic v, input logic h, input logic [3:0] rd,
      input logic [15:0] alu, input logic [15:0] mem,
      input logic [15:0] eRes, input logic eWen, input logic [3:0] eAddr,
      input logic ePc, input logic [3:0] eCnt, input logic eHlt);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; stall = st; flush = fl; wb_mux_contrl = sel;
      wb_enable_wb_in = we; pc_en_wb_in = v; halt_wb_in = h;
      rd_wb_in = rd; alu_result_wb_in = alu; mem_result_wb_in = mem;
      e.cyc = cycle; e.res = eRes; e.wen = eWen; e.addr = eAddr;
      e.pc = ePc; e.cnt = eCnt; e.hlt = eHlt;
      expQ.push_back(e);
      cycle++;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin : watchdog
      #20000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin : stimulus
      //               r  st fl sel we v  h  rd     alu       mem        eRes      eWen eAddr ePc eCnt eHlt
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 0, 4'd0, 0, 4'd0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd3, 16'd17,   16'h0000, 16'h0000, 0, 4'd0, 0, 4'd0, 0);
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 4'd7, 16'h1234, 16'hBEEF, 16'd17,   1, 4'd3, 1, 4'd0, 0);
      applyStimulus(0, 0, 0, 1, 1, 1, 0, 4'd0, 16'h1234, 16'hBEEF, 16'hBEEF, 1, 4'd7, 1, 4'd1, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd5, 16'h0055, 16'h0000, 16'hBEEF, 0, 4'd0, 1, 4'd2, 0);
      applyStimulus(0, 1, 0, 0, 1, 1, 0, 4'd9, 16'h0AAA, 16'h0000, 16'h0055, 0, 4'd5, 0, 4'd3, 0);
      applyStimulus(0, 1, 0, 0, 1, 1, 0, 4'd9, 16'h0AAA, 16'h0000, 16'h0055, 0, 4'd5, 0, 4'd3, 0);
      applyStimulus(0, 1, 0, 0, 1, 1, 0, 4'd9, 16'h0AAA, 16'h0000, 16'h0055, 0, 4'd5, 0, 4'd3, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd9, 16'h0AAA, 16'h0000, 16'h0055, 1, 4'd5, 1, 4'd3, 0);
      applyStimulus(0, 1, 1, 0, 1, 1, 0, 4'd10,16'h0BBB, 16'h0000, 16'h0AAA, 0, 4'd9, 0, 4'd4, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 1, 4'd2, 16'h0222, 16'h0000, 16'h0000, 0, 4'd0, 0, 4'd4, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd4, 16'h0333, 16'h0000, 16'h0222, 1, 4'd2, 1, 4'd4, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd6, 16'h0444, 16'h0000, 16'h0333, 0, 4'd4, 0, 4'd5, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0444, 0, 4'd6, 0, 4'd5, 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 0, 4'd0, 0, 4'd0, 0);

      // Seventeen back-to-back retirements wrap the 4-bit counter to 1.
      for (int k = 0; k < 17; k++) begin
         if (k == 0)
            applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd1, 16'(k + 1), 16'h0000, 16'h0000, 0, 4'd0, 0, 4'd0, 0);
         else
            applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd1, 16'(k + 1), 16'h0000, 16'(k), 1, 4'd1, 1, 4'((k - 1) % 16), 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'd17,   1, 4'd1, 1, 4'd0, 0);
      applyStimulus(0, 0, 0, 0, 1, 1, 0, 4'd8, 16'h0888, 16'h0000, 16'h0000, 0, 4'd0, 0, 4'd1, 0);
      applyStimulus(1, 1, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0888, 0, 4'd8, 0, 4'd1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'd0, 16'h0000, 16'h0000, 16'h0000, 0, 4'd0, 0, 4'd0, 0);

      @(negedge clk);
      #1;
      compared++;
      if (expQ.size() != 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
